rv32_wishbone_bridge: RTL
=========================

# rv32_wishbone_bridge

Memory-stage-1 bus master for the peripheral region (address[31:28] = 4'b0010). It converts a load or store presented by memory stage 1 into a single Wishbone classic cycle and stalls the pipeline until the cycle completes. Read data is returned as a held register that memory stage 2 selects for peripheral addresses. The block sits beside the data-RAM port, upstream of the memory stage 2 read-data mux.

## Interface
- TIMEOUT_CYCLES, 255: maximum Wishbone cycle length in clocks before the bridge aborts the cycle; ≥ 2.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- address_i  in  32  byte address from memory stage 1; the same net as the memory data address.
- write_enable_i  in  4  byte-lane strobes for a store; 0 = not a store.
- read_request_i  in  1  memory stage 1 holds a load.
- write_data_i  in  32  lane-aligned store data.
- hold_i  in  1  pipeline stall from other sources, excluding this block.
- stall_o  out  1  bridge stall request, ORed into the pipeline stall.
- read_data_o  out  32  last captured read data.
- bus_error_o  out  1  one-cycle pulse on a bus error or timeout.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination.

## Operation
- sel = (address_i[31:28] == 4'b0010) && (read_request_i || |write_enable_i).
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - If sel: latch the Wishbone request fields and go to BUS.
  - Latched fields: wb_adr_o = {address_i[31:2], 2'b00}; wb_we_o = |write_enable_i; wb_sel_o = write_enable_i for stores, 4'hF for loads; wb_dat_o = write_data_i.
  - Clear the timeout counter on entry to BUS.
- **BUS**
  - wb_cyc_o = wb_stb_o = 1.
  - On wb_err_i, with or without ack (err has priority):
    - drop cyc/stb;
    - for a load only, load read_data_o = 32'h0;
    - pulse bus_error_o;
    - go to DONE.
  - On wb_ack_i alone: drop cyc/stb; for a load only, load read_data_o = wb_dat_i; go to DONE.
  - On neither:
    - increment the counter;
    - if the counter == TIMEOUT_CYCLES-1, abort exactly as for err.
    - Result: at most TIMEOUT_CYCLES BUS cycles.
- **DONE**
  - stall_o is low, so the access advances out of memory stage 1 at the end of this cycle, provided hold_i is low.
  - If hold_i = 1, stay in DONE. Do not re-issue: the same access is still on address_i.
  - When hold_i = 0, go to IDLE.
- stall_o = (state == IDLE && sel) || state == BUS. Combinational, so the access is held in memory stage 1 from its first cycle.
- read_data_o changes only on load completion. It holds through the following memory stage 2 cycle and through any stall.
- Stores never modify read_data_o.
- wb_ack_i and wb_err_i are ignored outside BUS.

## Timing
- Reset values (asynchronous): state IDLE, wb_cyc_o/wb_stb_o/wb_we_o = 0, wb_adr_o/wb_dat_o = 0, wb_sel_o = 0, read_data_o = 0, bus_error_o = 0, counter = 0.
- Reset asserted mid-cycle drops wb_cyc_o/wb_stb_o immediately; no completion is reported.
- All Wishbone outputs are registered.
- Cycle sequence for an access first presented in cycle N:
  - cycle N: state IDLE, stall_o = 1;
  - cycles N+1 .. N+1+k: BUS, cyc/stb = 1, where k ≥ 0 is the number of slave wait cycles;
  - ack sampled at the edge ending cycle N+1+k;
  - cycle N+2+k: DONE, stall_o = 0, read_data_o valid;
  - cycle N+3+k: instruction in memory stage 2, read_data_o still valid.
- A zero-wait slave (ack in the first BUS cycle) gives 2 stall cycles per access.
- Back-to-back accesses: the next access can enter IDLE→BUS no earlier than the cycle after DONE. Minimum period is 3 cycles per access.
- Timeout: abort at the edge ending BUS cycle TIMEOUT_CYCLES. bus_error_o is high in the first DONE cycle only.
- Accesses to non-peripheral addresses never assert stall_o or cyc.

## Test plan
- **Load, zero-wait:** address 0x2000_0004, read_request_i=1, slave acks in the first BUS cycle with 0xCAFE_F00D. Expect wb_adr_o=0x2000_0004, wb_sel_o=4'hF, stall_o high for exactly 2 cycles, read_data_o=0xCAFE_F00D in DONE and in the following cycle.
- **Byte store with 3 wait cycles:** address 0x2000_0013, write_enable_i=4'b1000, data 0xAB00_0000. Expect wb_we_o=1, wb_sel_o=4'b1000, wb_adr_o=0x2000_0010, stall_o high for 5 cycles, read_data_o unchanged.
- **Error:** wb_err_i and wb_ack_i asserted together on a load. Expect read_data_o=0, a one-cycle bus_error_o pulse, and cyc dropped the next cycle.
- **Timeout:** TIMEOUT_CYCLES=4, slave silent. Expect cyc high for exactly 4 cycles, then bus_error_o pulse, read_data_o=0, stall_o released.
- **hold_i in DONE:** hold_i held high for 3 cycles during DONE. Expect no second Wishbone cycle, state remains DONE, then IDLE once hold_i falls. Afterwards a RAM-region access at 0x1000_0000 causes no cyc and no stall.
- **Reset mid-BUS:** rst_n_i low during the second BUS cycle. Expect all outputs at reset values asynchronously, and a clean new cycle after reset is released.

Source files
------------

// File: rtl/rv32_wishbone_bridge_if.sv
// Wishbone classic bus between the memory-stage peripheral bridge and the slave fabric.
interface rv32_wishbone_bridge_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/rv32_wishbone_bridge.sv
// Memory-stage-1 Wishbone master for the 0x2xxx_xxxx peripheral region: one classic
// cycle per load/store, pipeline stalled until the cycle ends, read data held afterwards.
module rv32_wishbone_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [31:0]                   address_i,
    input  logic [3:0]                    write_enable_i,
    input  logic                          read_request_i,
    input  logic [31:0]                   write_data_i,
    input  logic                          hold_i,
    output logic                          stall_o,
    output logic [31:0]                   read_data_o,
    output logic                          bus_error_o,
    rv32_wishbone_bridge_if.master        wb
);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic             sel, start, finish, abort, timeout;

    assign sel     = (address_i[31:28] == 4'b0010) && (read_request_i || (|write_enable_i));
    assign timeout = (count == CNT_LAST);
    assign stall_o = ((state == IDLE) && sel) || (state == BUS);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel) begin
                    start      = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // err outranks ack; silence on the last allowed cycle is treated as err
                if (wb.wb_err_i || (!wb.wb_ack_i && timeout)) begin
                    abort      = 1'b1;
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (wb.wb_ack_i) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!hold_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            count       <= '0;
            read_data_o <= '0;
            bus_error_o <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
        end else begin
            state       <= state_next;
            bus_error_o <= abort;
            if (start) begin
                wb.wb_cyc_o <= 1'b1;
                wb.wb_stb_o <= 1'b1;
                wb.wb_we_o  <= |write_enable_i;
                wb.wb_adr_o <= address_i & 32'hFFFF_FFFC;
                wb.wb_sel_o <= (|write_enable_i) ? write_enable_i : 4'hF;
                wb.wb_dat_o <= write_data_i;
                count       <= '0;
            end else if (finish) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                if (!wb.wb_we_o) read_data_o <= abort ? 32'h0 : wb.wb_dat_i;
            end else if (state == BUS) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule
